sequence_checker: RTL and testbench

//  Consumer of the LFSR random-symbol stream. Builds a growing sequence of

---
 rtl/sequence_checker.sv | 171 +++++++++++++++++
 tb/tb_sequence_checker.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_checker.sv
// sequence_checker: memory-game core. Grows a random symbol sequence one
// symbol per round, replays it on one-hot LEDs, then checks the player's
// button entries against it and reports score / win / lose.
module sequence_checker #(
  parameter int MAX_LEN        = 8,
  parameter int LEN_W          = 4,
  parameter int SHOW_CYCLES    = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       rand_in,
  input  logic             btn_valid,
  input  logic [1:0]       btn_code,
  output logic [2:0]       led_out,
  output logic             await_input,
  output logic [LEN_W-1:0] score,
  output logic             win,
  output logic             lose
);

  // One shared timer serves SHOW, GAP and INPUT; size it for the longest.
  localparam int TMAX_SG = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int TMAX    = (TMAX_SG > TIMEOUT_CYCLES) ? TMAX_SG : TIMEOUT_CYCLES;
  localparam int TMR_W   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TMR_W-1:0] SHOW_LAST = TMR_W'(SHOW_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_ADD, S_SHOW, S_GAP, S_INPUT, S_WIN, S_LOSE
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] score_q, score_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             seq_we;

  // Memory spans the full index range so every counter value is a legal index.
  logic [1:0]       seq_q [2**LEN_W];

  logic [LEN_W-1:0] last_idx;
  logic [1:0]       cur_sym;

  assign last_idx = len_q - 1'b1;
  assign cur_sym  = seq_q[idx_q];

  // Symbol 3 is not a playable symbol; the generator's 3 is folded onto 0.
  function automatic logic [1:0] fold_sym(input logic [1:0] s);
    return (s == 2'd3) ? 2'd0 : s;
  endfunction

  function automatic logic [2:0] sym_onehot(input logic [1:0] s);
    return 3'b001 << s;
  endfunction

  // Control state: FSM, counters and timer, cleared by the async reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      score_q <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      score_q <= score_d;
      tmr_q   <= tmr_d;
    end
  end

  // Sequence storage: append the folded random symbol during ADD.
  always_ff @(posedge clk) begin
    if (seq_we) seq_q[len_q] <= fold_sym(rand_in);
  end

  // Next-state logic for the game flow.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    score_d = score_q;
    tmr_d   = tmr_q;
    seq_we  = 1'b0;
    case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start) begin
          state_d = S_ADD;
          len_d   = '0;
          idx_d   = '0;
          score_d = '0;
          tmr_d   = '0;
        end
      end
      S_ADD: begin
        seq_we  = 1'b1;
        len_d   = len_q + 1'b1;
        idx_d   = '0;
        tmr_d   = '0;
        state_d = S_SHOW;
      end
      S_SHOW: begin
        if (tmr_q == SHOW_LAST) begin
          tmr_d   = '0;
          state_d = S_GAP;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_GAP: begin
        if (tmr_q == GAP_LAST) begin
          tmr_d = '0;
          if (idx_q == last_idx) begin
            idx_d   = '0;
            state_d = S_INPUT;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_SHOW;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_INPUT: begin
        // An entry in the same cycle as the timeout takes priority.
        if (btn_valid) begin
          tmr_d = '0;
          if (btn_code == 2'd3 || btn_code != cur_sym) begin
            state_d = S_LOSE;
          end else if (idx_q == last_idx) begin
            score_d = score_q + 1'b1;
            idx_d   = '0;
            state_d = (len_q == MAX_LEN_L) ? S_WIN : S_ADD;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (tmr_q == TO_LAST) begin
          state_d = S_LOSE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded purely from registered state.
  always_comb begin
    led_out     = 3'b000;
    await_input = 1'b0;
    win         = 1'b0;
    lose        = 1'b0;
    score       = score_q;
    case (state_q)
      S_SHOW:  led_out     = sym_onehot(cur_sym);
      S_INPUT: await_input = 1'b1;
      S_WIN:   win         = 1'b1;
      S_LOSE:  lose        = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sequence_checker.sv
// Testbench for sequence_checker: directed scenarios followed by randomized
// games, checked against a queue-based model of the game rules.
module tb_sequence_checker;

  localparam int MAXL  = 2;
  localparam int SHOWC = 2;
  localparam int GAPC  = 1;
  localparam int TO    = 5;

  localparam int P_IDLE  = 0;
  localparam int P_ADD   = 1;
  localparam int P_INPUT = 2;
  localparam int P_WIN   = 3;
  localparam int P_LOSE  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] rand_in;
  logic       btn_valid;
  logic [1:0] btn_code;
  logic [2:0] led_out;
  logic       await_input;
  logic [3:0] score;
  logic       win;
  logic       lose;

  int seq_m[$];
  int idx_m;
  int score_m;
  int phase_m;
  int checks;
  int failures;

  sequence_checker #(
    .MAX_LEN(MAXL), .LEN_W(4), .SHOW_CYCLES(SHOWC),
    .GAP_CYCLES(GAPC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .rand_in(rand_in),
    .btn_valid(btn_valid), .btn_code(btn_code), .led_out(led_out),
    .await_input(await_input), .score(score), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [2:0] led, input logic aw,
                          input int sc, input logic w, input logic l);
    chk({tag, ".led"},   32'(led_out),     32'(led));
    chk({tag, ".await"}, 32'(await_input), 32'(aw));
    chk({tag, ".score"}, 32'(score),       sc);
    chk({tag, ".win"},   32'(win),         32'(w));
    chk({tag, ".lose"},  32'(lose),        32'(l));
  endtask

  // Outputs expected whenever no LED is being replayed.
  task automatic chk_phase(input string tag);
    chk_outs(tag, 3'b000, phase_m == P_INPUT, score_m, phase_m == P_WIN, phase_m == P_LOSE);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Call while in ADD: supplies the random symbol, leaves the DUT in SHOW.
  task automatic add_sym(input logic [1:0] r);
    rand_in = r;
    seq_m.push_back((r == 2'd3) ? 0 : int'(r));
    tick();
    rand_in = 2'($urandom_range(0, 3));
  endtask

  task automatic do_start(input logic [1:0] r);
    start = 1'b1;
    tick();
    start = 1'b0;
    seq_m.delete();
    score_m = 0;
    idx_m   = 0;
    phase_m = P_ADD;
    chk_phase("start_add");
    add_sym(r);
  endtask

  // Each stored symbol: SHOWC lit cycles, then GAPC dark cycles, then INPUT.
  task automatic replay(input bit poke);
    for (int i = 0; i < seq_m.size(); i++) begin
      for (int c = 0; c < SHOWC; c++) begin
        chk_outs($sformatf("show%0d_%0d", i, c), 3'(1 << seq_m[i]), 1'b0, score_m, 1'b0, 1'b0);
        if (poke && i == 0 && c == 0) begin
          btn_valid = 1'b1;
          btn_code  = 2'd3;
          start     = 1'b1;
        end
        tick();
        btn_valid = 1'b0;
        start     = 1'b0;
      end
      for (int c = 0; c < GAPC; c++) begin
        chk_outs($sformatf("gap%0d", i), 3'b000, 1'b0, score_m, 1'b0, 1'b0);
        tick();
      end
    end
    idx_m   = 0;
    phase_m = P_INPUT;
    chk_phase("input_entry");
  endtask

  // Wait 'delay' idle cycles in INPUT, then enter 'code'.
  task automatic enter(input logic [1:0] code, input int delay);
    for (int d = 0; d < delay; d++) begin
      tick();
      if (d == TO - 1) begin
        phase_m = P_LOSE;
        chk_phase("timeout");
        return;
      end
      chk_phase("waiting");
    end
    btn_valid = 1'b1;
    btn_code  = code;
    tick();
    btn_valid = 1'b0;
    btn_code  = 2'($urandom_range(0, 3));
    if (int'(code) == seq_m[idx_m]) begin
      if (idx_m == seq_m.size() - 1) begin
        score_m++;
        idx_m   = 0;
        phase_m = (seq_m.size() == MAXL) ? P_WIN : P_ADD;
      end else begin
        idx_m++;
      end
    end else begin
      phase_m = P_LOSE;
    end
    chk_phase($sformatf("press%0d", code));
  endtask

  task automatic hold_check(input string tag);
    tick();
    chk_phase(tag);
    btn_valid = 1'b1;
    btn_code  = 2'($urandom_range(0, 3));
    tick();
    btn_valid = 1'b0;
    chk_phase({tag, "_btn"});
  endtask

  task automatic play_random_game();
    int         roll;
    int         delay;
    logic [1:0] code;
    do_start(2'($urandom_range(0, 3)));
    replay(1'b0);
    while (phase_m == P_INPUT) begin
      roll  = $urandom_range(0, 11);
      code  = 2'(seq_m[idx_m]);
      delay = $urandom_range(0, TO - 1);
      if (roll == 0) code = 2'((seq_m[idx_m] + 1 + $urandom_range(0, 2)) % 4);
      if (roll == 1) delay = TO;
      enter(code, delay);
      if (phase_m == P_ADD) begin
        add_sym(2'($urandom_range(0, 3)));
        replay(1'b0);
      end
    end
    hold_check("end_hold");
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    start     = 1'b0;
    btn_valid = 1'b0;
    btn_code  = 2'd0;
    rand_in   = 2'd0;
    score_m   = 0;
    idx_m     = 0;
    phase_m   = P_IDLE;

    // Reset state, then button pulses before start are ignored.
    repeat (2) tick();
    chk_phase("reset");
    reset = 1'b1;
    hold_check("idle");

    // Two-round win: {1} then {1,0} (rand 3 folds to 0).
    do_start(2'd1);
    replay(1'b0);
    enter(2'd1, 0);
    add_sym(2'd3);
    replay(1'b0);
    enter(2'd1, 1);
    enter(2'd0, 2);
    repeat (3) hold_check("win_hold");

    // Wrong symbol in round 1.
    do_start(2'd2);
    replay(1'b0);
    enter(2'd0, 0);
    hold_check("lose_hold");

    // Timeout with no entry, then an entry on the last allowed cycle.
    do_start(2'($urandom_range(0, 3)));
    replay(1'b0);
    enter(2'(seq_m[0]), TO);
    do_start(2'd1);
    replay(1'b0);
    enter(2'd1, TO - 1);
    add_sym(2'd2);
    replay(1'b0);
    enter(2'd1, TO - 1);
    enter(2'd2, TO - 1);

    // Illegal code loses; button and start during SHOW leave replay intact.
    do_start(2'd2);
    replay(1'b1);
    enter(2'd3, 0);

    // Restart from LOSE.
    do_start(2'd0);
    replay(1'b0);
    enter(2'd0, 3);
    add_sym(2'd2);
    replay(1'b0);
    enter(2'd0, 0);
    enter(2'd1, 0);

    // Asynchronous reset in the middle of SHOW clears outputs at once.
    do_start(2'd1);
    #2 reset = 1'b0;
    #1;
    phase_m = P_IDLE;
    score_m = 0;
    chk_phase("async_rst_show");
    tick();
    reset = 1'b1;
    tick();
    chk_phase("after_rst_show");

    // Asynchronous reset while waiting for input.
    do_start(2'd2);
    replay(1'b0);
    enter(2'd2, 0);
    add_sym(2'd0);
    replay(1'b0);
    #2 reset = 1'b0;
    #1;
    phase_m = P_IDLE;
    score_m = 0;
    chk_phase("async_rst_input");
    tick();
    reset = 1'b1;
    hold_check("after_rst_input");

    // Randomized games.
    for (int g = 0; g < 25; g++) play_random_game();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
